// File: rtl/knn_stream_sorter.sv
// Insertion-sorting collector for the recomputed-KNN stream: keeps K entries ordered
// by distance (invalid entries sort as maximum) and pulses done when K have arrived.
package knn_pkg;
    localparam int BIT_WIDTH  = 8;
    localparam int ADDR_WIDTH = 10;

    typedef struct packed {
        logic [BIT_WIDTH-1:0]   x;
        logic [BIT_WIDTH-1:0]   y;
        logic [BIT_WIDTH-1:0]   z;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [2*BIT_WIDTH-1:0] distance;
        logic                   valid;
    } knn_entry_t;

    localparam knn_entry_t EMPTY_ENTRY = '{
        x: '0, y: '0, z: '0, addr: '0, distance: '1, valid: 1'b0
    };
endpackage

module knn_stream_sorter
    import knn_pkg::*;
#(
    parameter int K = 4,
    localparam int CW = $clog2(K + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             valid_in,
    input  knn_entry_t       entry_in,
    output knn_entry_t       sorted_out [0:K-1],
    output logic [CW-1:0]    count_out,
    output logic             busy,
    output logic             done,
    output logic             overflow
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } state_t;

    state_t                 state_reg, state_next;
    knn_entry_t             slot_reg  [0:K-1];
    knn_entry_t             slot_next [0:K-1];
    knn_entry_t             ins_slot  [0:K-1];
    logic [CW-1:0]          count_reg, count_next;
    logic                   overflow_reg, overflow_next;
    logic                   done_reg, done_next;
    logic                   busy_reg;
    logic [K-1:0]           gt;
    logic [2*BIT_WIDTH-1:0] new_key;

    assign new_key = entry_in.valid ? entry_in.distance : '1;

    // Slots at or beyond count are empty and outrank any key, so an invalid entry
    // (key all-ones) still lands after the occupied slots. gt is monotonic across slots.
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_slot
            logic [2*BIT_WIDTH-1:0] slot_key;
            assign slot_key = slot_reg[gi].valid ? slot_reg[gi].distance : '1;
            assign gt[gi]   = (CW'(gi) >= count_reg) || (slot_key > new_key);

            if (gi == 0) begin : g_head
                assign ins_slot[gi] = gt[gi] ? entry_in : slot_reg[gi];
            end else begin : g_tail
                assign ins_slot[gi] = !gt[gi]     ? slot_reg[gi]   :
                                      !gt[gi - 1] ? entry_in       :
                                                    slot_reg[gi - 1];
            end
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        done_next     = 1'b0;
        slot_next     = slot_reg;

        if (start) begin
            state_next    = ST_COLLECT;
            count_next    = '0;
            overflow_next = 1'b0;
            for (int i = 0; i < K; i++) begin
                slot_next[i] = EMPTY_ENTRY;
            end
        end else if (valid_in) begin
            if (state_reg == ST_COLLECT) begin
                slot_next  = ins_slot;
                count_next = count_reg + 1'b1;
                if (count_reg == CW'(K - 1)) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end
            end else begin
                overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            for (int i = 0; i < K; i++) begin
                slot_reg[i] <= EMPTY_ENTRY;
            end
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            done_reg     <= done_next;
            busy_reg     <= (state_next == ST_COLLECT);
            slot_reg     <= slot_next;
        end
    end

    assign sorted_out = slot_reg;
    assign count_out  = count_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign overflow   = overflow_reg;
endmodule

// File: tb/tb_knn_stream_sorter.sv
// Scoreboard bench for knn_stream_sorter (K=4): expected sorted lists are queued as
// stimulus is issued and checked by a monitor whenever done pulses.
module tb_knn_stream_sorter;
    import knn_pkg::*;

    localparam int K  = 4;
    localparam int CW = $clog2(K + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          valid_in;
    knn_entry_t    entry_in;
    knn_entry_t    sorted_out [0:K-1];
    logic [CW-1:0] count_out;
    logic          busy;
    logic          done;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] d [0:K-1];
        logic [9:0]  a [0:K-1];
        logic        v [0:K-1];
    } exp_t;

    exp_t exp_q [$];

    knn_stream_sorter #(.K(K)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .valid_in   (valid_in),
        .entry_in   (entry_in),
        .sorted_out (sorted_out),
        .count_out  (count_out),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic push_exp(input logic [15:0] d0, d1, d2, d3,
                            input logic [9:0] a0, a1, a2, a3, input logic [3:0] v);
        exp_t e;
        e.d[0] = d0; e.d[1] = d1; e.d[2] = d2; e.d[3] = d3;
        e.a[0] = a0; e.a[1] = a1; e.a[2] = a2; e.a[3] = a3;
        for (int i = 0; i < K; i++) e.v[i] = v[3-i];
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus: drive just after a rising edge, hold across the next edge.
    task automatic drive(input logic s, input logic v, input logic [15:0] d,
                         input logic [9:0] a, input logic ev);
        start    = s;
        valid_in = v;
        entry_in = '{x: d[7:0], y: a[7:0], z: 8'h5a, addr: a, distance: d, valid: ev};
        @(posedge clk);
        #1;
        start    = 1'b0;
        valid_in = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic [9:0] a);
        drive(1'b0, 1'b1, d, a, 1'b1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected actual=1 required=0 at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                for (int i = 0; i < K; i++) begin
                    chk($sformatf("slot%0d {valid,addr,dist}", i),
                        {5'd0, sorted_out[i].valid, sorted_out[i].addr, sorted_out[i].distance},
                        {5'd0, e.v[i], e.a[i], e.d[i]});
                end
                chk("done_count", 32'(count_out), K);
                chk("done_busy", 32'(busy), 0);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        valid_in = 1'b0;
        entry_in = EMPTY_ENTRY;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        chk("reset_count", 32'(count_out), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_overflow", 32'(overflow), 0);
        chk("reset_slot0", {15'd0, sorted_out[0].valid, sorted_out[0].distance}, 32'h0_ffff);

        // 1: basic sort
        push_exp(5, 10, 20, 30, 4, 2, 3, 1, 4'b1111);
        drive(1'b1, 1'b0, 0, 0, 1'b0);
        chk("t1_busy_after_start", 32'(busy), 1);
        send(30, 1);
        chk("t1_latency_slot0", 32'(sorted_out[0].distance), 30);
        send(10, 2); send(20, 3); send(5, 4);
        drain("t1_drained");

        // 2: tie stability
        push_exp(7, 10, 10, 10, 4, 1, 2, 3, 4'b1111);
        drive(1'b1, 1'b0, 0, 0, 1'b0);
        send(10, 1); send(10, 2); send(7, 4); send(10, 3);
        drain("t2_drained");

        // 3: invalid entry sorts last but is stored and counted
        push_exp(1, 8, 9, 3, 4, 2, 3, 1, 4'b1110);
        drive(1'b1, 1'b0, 0, 0, 1'b0);
        drive(1'b0, 1'b1, 3, 1, 1'b0);
        send(8, 2); send(9, 3); send(1, 4);
        drain("t3_drained");

        // 4: restart mid-collection
        push_exp(1, 2, 3, 4, 4, 3, 2, 1, 4'b1111);
        drive(1'b1, 1'b0, 0, 0, 1'b0);
        send(50, 8); send(60, 9);
        drive(1'b1, 1'b0, 0, 0, 1'b0);
        chk("t4_count_restart", 32'(count_out), 0);
        send(4, 1); send(3, 2); send(2, 3); send(1, 4);
        drain("t4_drained");

        // 5: overflow in DONE, then start colliding with valid_in
        send(0, 7);
        chk("t5_overflow_set", 32'(overflow), 1);
        chk("t5_count_held", 32'(count_out), 4);
        chk("t5_slot0_held", 32'(sorted_out[0].distance), 1);
        chk("t5_busy_done", 32'(busy), 0);
        drive(1'b1, 1'b1, 7, 7, 1'b1);
        chk("t5_overflow_cleared", 32'(overflow), 0);
        chk("t5_count_zero", 32'(count_out), 0);
        chk("t5_busy_collect", 32'(busy), 1);
        chk("t5_entry_dropped", 32'(sorted_out[0].valid), 0);

        // 6: async reset mid-collection, then a full run
        drive(1'b1, 1'b0, 0, 0, 1'b0);
        send(12, 1); send(11, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_reset_count", 32'(count_out), 0);
        chk("t6_reset_busy", 32'(busy), 0);
        chk("t6_reset_done", 32'(done), 0);
        chk("t6_reset_slot0", {15'd0, sorted_out[0].valid, sorted_out[0].distance}, 32'h0_ffff);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        push_exp(39, 40, 41, 42, 3, 1, 2, 4, 4'b1111);
        drive(1'b1, 1'b0, 0, 0, 1'b0);
        send(40, 1); send(41, 2); send(39, 3); send(42, 4);
        drain("t6_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
